// File: rtl/water_pkg.sv
// Shared types and helpers for the water-supply control blocks.
package water_pkg;

  typedef enum logic [1:0] {
    LVL_CRITICAL = 2'b00,
    LVL_LOW      = 2'b01,
    LVL_MID      = 2'b10,
    LVL_HIGH     = 2'b11
  } level_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FILLING = 2'b01,
    ST_SETTLE  = 2'b10,
    ST_FAULT   = 2'b11
  } pump_state_t;

  localparam int FILL_COUNT_W = 16;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/water_tick_gen.sv
// Free-running divider: pulses tick for one cycle every TICK_DIV clocks.
module water_tick_gen
  import water_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int              DIV_W = cnt_width(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_div;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_div == LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign tick = (r_div == LAST);

endmodule

// File: rtl/water_pump_controller.sv
// Refill sequencer for the supply pump and inlet valve, with timeout fault and critical alarm.
// Optional WATER_PUMP_STATS_EN adds a saturating fill_count output.
module water_pump_controller
  import water_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int MIN_RUN_TICKS = 5,
  parameter int TIMEOUT_TICKS = 60,
  parameter int SETTLE_TICKS  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] encoded_water,
  input  logic       enable,
  input  logic       fault_clear,
  output logic       pump_on,
  output logic       valve_open,
  output logic       fault,
  output logic       alarm_critical,
  output logic [1:0] state
`ifdef WATER_PUMP_STATS_EN
  ,
  output logic [FILL_COUNT_W-1:0] fill_count
`endif
);

  localparam int RUN_W = cnt_width(MIN_RUN_TICKS);
  localparam int TO_W  = cnt_width(TIMEOUT_TICKS);
  localparam int SET_W = cnt_width(SETTLE_TICKS);
  localparam logic [RUN_W-1:0] RUN_LIM    = RUN_W'(MIN_RUN_TICKS);
  localparam logic [TO_W-1:0]  TO_LIM     = TO_W'(TIMEOUT_TICKS);
  localparam logic [SET_W-1:0] SETTLE_LIM = SET_W'(SETTLE_TICKS);

  logic             w_tick;
  logic             w_enter;
  logic             w_rise;
  level_t           r_lvl_q;
  level_t           r_lvl_prev;
  pump_state_t      r_state;
  pump_state_t      w_state_next;
  logic [RUN_W-1:0] r_run_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [SET_W-1:0] r_settle_cnt;

  water_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );

  // NOTE: default assigned before the case so no path leaves w_state_next unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:
        if (enable && (r_lvl_q <= LVL_LOW)) w_state_next = ST_FILLING;
      ST_FILLING:
        if (!enable)                                          w_state_next = ST_IDLE;
        else if ((r_lvl_q == LVL_HIGH) && (r_run_cnt >= RUN_LIM)) w_state_next = ST_SETTLE;
        else if (r_to_cnt == TO_LIM)                          w_state_next = ST_FAULT;
      ST_SETTLE:
        if (r_settle_cnt == SETTLE_LIM) w_state_next = ST_IDLE;
      ST_FAULT:
        if (fault_clear) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_enter = (w_state_next != r_state);
  assign w_rise  = (r_lvl_q > r_lvl_prev);

  // Counters only matter in their own state; state entry restarts them all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_cnt    <= '0;
      r_to_cnt     <= '0;
      r_settle_cnt <= '0;
    end else if (w_enter) begin
      r_run_cnt    <= '0;
      r_to_cnt     <= '0;
      r_settle_cnt <= '0;
    end else begin
      if (w_tick && (r_run_cnt != RUN_LIM)) r_run_cnt <= r_run_cnt + 1'b1;
      if (w_rise)                                r_to_cnt <= '0;
      else if (w_tick && (r_to_cnt != TO_LIM))   r_to_cnt <= r_to_cnt + 1'b1;
      if (w_tick && (r_settle_cnt != SETTLE_LIM)) r_settle_cnt <= r_settle_cnt + 1'b1;
    end
  end

  // Drive outputs from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_lvl_q        <= LVL_CRITICAL;
      r_lvl_prev     <= LVL_CRITICAL;
      pump_on        <= 1'b0;
      valve_open     <= 1'b0;
      fault          <= 1'b0;
      alarm_critical <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_lvl_q        <= level_t'(encoded_water);
      r_lvl_prev     <= r_lvl_q;
      pump_on        <= (w_state_next == ST_FILLING);
      valve_open     <= (w_state_next == ST_FILLING);
      fault          <= (w_state_next == ST_FAULT);
      alarm_critical <= (encoded_water == LVL_CRITICAL);
    end
  end

  assign state = r_state;

`ifdef WATER_PUMP_STATS_EN
  logic [FILL_COUNT_W-1:0] r_fill_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fill_count <= '0;
    end else if ((r_state == ST_FILLING) && (w_state_next == ST_SETTLE) && (r_fill_count != '1)) begin
      r_fill_count <= r_fill_count + 1'b1;
    end
  end

  assign fill_count = r_fill_count;
`endif

endmodule
